// File: rtl/de_pipe_reg_if.sv
// rtl/de_pipe_reg_if.sv - decode/execute pipeline register bus
interface de_pipe_reg_if #(
   parameter int CNT_W = 16
);
   logic             D_valid;
   logic [5:0]       D_op;
   logic [31:0]      D_valA;
   logic [31:0]      D_valC;
   logic [4:0]       D_srcA;
   logic [4:0]       D_srcB;
   logic             D_useB;
   logic [4:0]       D_dst;
   logic             ext_stall;
   logic             flush;
   logic             E_valid;
   logic [5:0]       E_op;
   logic [31:0]      E_valA;
   logic [31:0]      E_valC;
   logic [4:0]       E_dst;
   logic             d_stall;
   logic [CNT_W-1:0] bubble_cnt;

   modport master (
      output D_valid, D_op, D_valA, D_valC, D_srcA, D_srcB, D_useB, D_dst,
             ext_stall, flush,
      input  E_valid, E_op, E_valA, E_valC, E_dst, d_stall, bubble_cnt
   );

   modport slave (
      input  D_valid, D_op, D_valA, D_valC, D_srcA, D_srcB, D_useB, D_dst,
             ext_stall, flush,
      output E_valid, E_op, E_valA, E_valC, E_dst, d_stall, bubble_cnt
   );
endinterface

// File: rtl/de_pipe_reg.sv
// rtl/de_pipe_reg.sv - decode-to-execute pipeline register with load-use bubble insertion
module de_pipe_reg #(
   parameter logic [5:0] OP_LW = 6'b100011,
   parameter int         CNT_W = 16
) (
   input logic          clk,
   input logic          rst_n,
   de_pipe_reg_if.slave bus
);
   logic             eValidQ;
   logic [5:0]       eOpQ;
   logic [31:0]      eValAQ;
   logic [31:0]      eValCQ;
   logic [4:0]       eDstQ;
   logic [CNT_W-1:0] bubbleCntQ;
   logic             hazard;
   logic             srcAHit;
   logic             srcBHit;

   // $0 is never written, so a load targeting it cannot create a dependency.
   always_comb begin
      srcAHit = (bus.D_srcA == eDstQ);
      srcBHit = bus.D_useB && (bus.D_srcB == eDstQ);
      hazard  = eValidQ && (eOpQ == OP_LW) && (eDstQ != 5'd0) && bus.D_valid
                && (srcAHit || srcBHit);
   end

   assign bus.d_stall    = bus.ext_stall | (hazard & ~bus.flush);
   assign bus.E_valid    = eValidQ;
   assign bus.E_op       = eOpQ;
   assign bus.E_valA     = eValAQ;
   assign bus.E_valC     = eValCQ;
   assign bus.E_dst      = eDstQ;
   assign bus.bubble_cnt = bubbleCntQ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eValidQ    <= 1'b0;
         eOpQ       <= 6'd0;
         eValAQ     <= 32'd0;
         eValCQ     <= 32'd0;
         eDstQ      <= 5'd0;
         bubbleCntQ <= '0;
      end else if (bus.ext_stall) begin
         eValidQ    <= eValidQ;
      end else if (bus.flush || hazard) begin
         // All-zero fields are the no-op bubble encoding.
         eValidQ <= 1'b0;
         eOpQ    <= 6'd0;
         eValAQ  <= 32'd0;
         eValCQ  <= 32'd0;
         eDstQ   <= 5'd0;
         if (bubbleCntQ != {CNT_W{1'b1}}) begin
            bubbleCntQ <= bubbleCntQ + 1'b1;
         end
      end else begin
         eValidQ <= bus.D_valid;
         eOpQ    <= bus.D_op;
         eValAQ  <= bus.D_valA;
         eValCQ  <= bus.D_valC;
         eDstQ   <= bus.D_dst;
      end
   end
endmodule

// File: tb/tb_de_pipe_reg.sv
// tb/tb_de_pipe_reg.sv - self-checking bench for de_pipe_reg
module tb_de_pipe_reg;
   localparam logic [5:0] IROP  = 6'b000000;
   localparam logic [5:0] IADDI = 6'b001000;
   localparam logic [5:0] IANDI = 6'b001100;
   localparam logic [5:0] IORI  = 6'b001101;
   localparam logic [5:0] ILW   = 6'b100011;
   localparam logic [5:0] ISW   = 6'b101011;
   localparam int         SAT   = 65535;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   de_pipe_reg_if #(.CNT_W(16)) bus ();

   de_pipe_reg #(.OP_LW(ILW), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        valid;
      bit [5:0]  op;
      bit [31:0] valA;
      bit [31:0] valC;
      bit [4:0]  dst;
   } inst_t;

   inst_t inE;
   int    mCnt;

   // A load in E blocks a decode instruction that names its destination.
   function automatic bit readsLoadResult();
      bit reads;
      reads = (bus.D_srcA == inE.dst) || (bus.D_useB && bus.D_srcB == inE.dst);
      return inE.valid && inE.op == ILW && inE.dst != 0 && bus.D_valid && reads;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inE  = '{0, 0, 0, 0, 0};
         mCnt = 0;
      end else if (bus.ext_stall) begin
         inE = inE;
      end else if (bus.flush || readsLoadResult()) begin
         inE  = '{0, 0, 0, 0, 0};
         mCnt = (mCnt + 1 > SAT) ? SAT : mCnt + 1;
      end else begin
         inE = '{bus.D_valid, bus.D_op, bus.D_valA, bus.D_valC, bus.D_dst};
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("m_valid", 64'(bus.E_valid), 64'(inE.valid));
      chk("m_op", 64'(bus.E_op), 64'(inE.op));
      chk("m_valA", 64'(bus.E_valA), 64'(inE.valA));
      chk("m_valC", 64'(bus.E_valC), 64'(inE.valC));
      chk("m_dst", 64'(bus.E_dst), 64'(inE.dst));
      chk("m_cnt", 64'(bus.bubble_cnt), 64'(mCnt));
      chk("m_dstall", 64'(bus.d_stall),
          64'(bus.ext_stall | (readsLoadResult() & ~bus.flush)));
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic setD(input logic [5:0] op, input logic [31:0] a, input logic [31:0] c,
                       input logic [4:0] sa, input logic [4:0] sb, input logic ub,
                       input logic [4:0] dst);
      bus.D_valid = 1'b1;
      bus.D_op    = op;
      bus.D_valA  = a;
      bus.D_valC  = c;
      bus.D_srcA  = sa;
      bus.D_srcB  = sb;
      bus.D_useB  = ub;
      bus.D_dst   = dst;
   endtask

   task automatic litE(input string name, input logic v, input logic [5:0] op,
                       input logic [31:0] a, input int cnt);
      chk({name, "_valid"}, 64'(bus.E_valid), 64'(v));
      chk({name, "_op"}, 64'(bus.E_op), 64'(op));
      chk({name, "_valA"}, 64'(bus.E_valA), 64'(a));
      chk({name, "_cnt"}, 64'(bus.bubble_cnt), 64'(cnt));
   endtask

   initial begin
      logic [5:0] passOps [4];
      int         guard;
      passOps = '{IROP, IANDI, IORI, ISW};
      bus.ext_stall = 1'b0;
      bus.flush     = 1'b0;
      setD(IADDI, 35, 17, 1, 2, 1'b0, 3);

      // reset held over two edges
      tick();
      tick();
      litE("rst", 1'b0, 6'd0, 32'd0, 0);
      chk("rst_valC", 64'(bus.E_valC), 64'd0);
      chk("rst_dst", 64'(bus.E_dst), 64'd0);
      rst_n = 1'b1;
      tick();
      litE("rst_rel", 1'b1, IADDI, 32'd35, 0);
      chk("rst_rel_valC", 64'(bus.E_valC), 64'd17);

      // passthrough
      for (int i = 0; i < 4; i++) begin
         setD(passOps[i], 32'(i + 1), 32'(i + 100), 5'(i + 10), 5'd0, 1'b0, 5'(i + 1));
         tick();
         litE("pass", 1'b1, passOps[i], 32'(i + 1), 0);
         chk("pass_dstall", 64'(bus.d_stall), 64'd0);
      end

      // load-use on operand A
      setD(ILW, 32'h40, 32'h4, 5'd1, 5'd0, 1'b0, 5'd8);
      tick();
      setD(IADDI, 32'h11, 32'h22, 5'd8, 5'd0, 1'b0, 5'd2);
      #1 chk("lu_dstall", 64'(bus.d_stall), 64'd1);
      tick();
      litE("lu_bubble", 1'b0, 6'd0, 32'd0, 1);
      chk("lu_dstall_clr", 64'(bus.d_stall), 64'd0);
      tick();
      litE("lu_after", 1'b1, IADDI, 32'h11, 1);

      // load to $0 never stalls
      setD(ILW, 32'h40, 32'h4, 5'd1, 5'd0, 1'b0, 5'd0);
      tick();
      setD(IADDI, 32'h12, 32'h0, 5'd0, 5'd0, 1'b0, 5'd2);
      #1 chk("lu0_dstall", 64'(bus.d_stall), 64'd0);
      tick();
      litE("lu0_after", 1'b1, IADDI, 32'h12, 1);

      // operand-B hazard, with and without useB
      setD(ILW, 32'h50, 32'h8, 5'd1, 5'd0, 1'b0, 5'd9);
      tick();
      setD(ISW, 32'h13, 32'h0, 5'd1, 5'd9, 1'b1, 5'd0);
      #1 chk("lb_dstall", 64'(bus.d_stall), 64'd1);
      tick();
      litE("lb_bubble", 1'b0, 6'd0, 32'd0, 2);
      tick();
      litE("lb_after", 1'b1, ISW, 32'h13, 2);
      setD(ILW, 32'h50, 32'h8, 5'd1, 5'd0, 1'b0, 5'd9);
      tick();
      setD(ISW, 32'h14, 32'h0, 5'd1, 5'd9, 1'b0, 5'd0);
      #1 chk("lbn_dstall", 64'(bus.d_stall), 64'd0);
      tick();
      litE("lbn_after", 1'b1, ISW, 32'h14, 2);

      // ext_stall holds E for three edges
      setD(IORI, 32'h5A, 32'h1, 5'd3, 5'd0, 1'b0, 5'd4);
      tick();
      setD(IADDI, 32'h7, 32'h2, 5'd3, 5'd0, 1'b0, 5'd5);
      bus.ext_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         litE("es_hold", 1'b1, IORI, 32'h5A, 2);
         chk("es_dstall", 64'(bus.d_stall), 64'd1);
      end
      bus.ext_stall = 1'b0;
      tick();
      litE("es_rel", 1'b1, IADDI, 32'h7, 2);

      // flush wins over a load-use hazard
      setD(ILW, 32'h60, 32'h0, 5'd1, 5'd0, 1'b0, 5'd5);
      tick();
      setD(IADDI, 32'h15, 32'h0, 5'd5, 5'd0, 1'b0, 5'd6);
      bus.flush = 1'b1;
      #1 chk("fh_dstall", 64'(bus.d_stall), 64'd0);
      tick();
      bus.flush = 1'b0;
      litE("fh_bubble", 1'b0, 6'd0, 32'd0, 3);
      tick();
      litE("fh_after", 1'b1, IADDI, 32'h15, 3);

      // ext_stall during hazard defers the bubble
      setD(ILW, 32'h70, 32'h0, 5'd1, 5'd0, 1'b0, 5'd6);
      tick();
      setD(IADDI, 32'h16, 32'h0, 5'd6, 5'd0, 1'b0, 5'd7);
      bus.ext_stall = 1'b1;
      tick();
      tick();
      litE("eh_hold", 1'b1, ILW, 32'h70, 3);
      chk("eh_dstall", 64'(bus.d_stall), 64'd1);
      bus.ext_stall = 1'b0;
      tick();
      litE("eh_bubble", 1'b0, 6'd0, 32'd0, 4);
      tick();
      litE("eh_after", 1'b1, IADDI, 32'h16, 4);

      // reset mid-stall clears everything, then D loads normally
      bus.ext_stall = 1'b1;
      tick();
      rst_n = 1'b0;
      #1 litE("mrst", 1'b0, 6'd0, 32'd0, 0);
      tick();
      bus.ext_stall = 1'b0;
      rst_n = 1'b1;
      setD(IANDI, 32'h21, 32'h0, 5'd1, 5'd0, 1'b0, 5'd2);
      tick();
      litE("mrst_rel", 1'b1, IANDI, 32'h21, 0);

      // saturation of the bubble counter
      bus.flush = 1'b1;
      guard = 0;
      while (mCnt < SAT && guard < 70000) begin
         tick();
         guard++;
      end
      chk("sat_reach", 64'(mCnt), 64'(SAT));
      tick();
      tick();
      chk("sat_hold", 64'(bus.bubble_cnt), 64'hFFFF);
      bus.flush = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
